// File: rtl/osc_pkg.sv
// Shared constants, state encoding and divisor/noise helpers for note_oscillator.
// OSC_NOISE_EN selects the LFSR-driven Q byte; LFSR constants live here either way.
package osc_pkg;

  localparam int DIV_W  = 19;
  localparam int NOTE_W = 4;
  localparam int OCT_W  = 3;

  localparam logic [DIV_W-1:0] DIV_ZERO = 19'd0;
  localparam logic [DIV_W-1:0] DIV_ONE  = 19'd1;
  localparam logic [OCT_W-1:0] OCT_MAX  = 3'd5;

  // Rounded 12e6/f for C2..B2; higher octaves are right shifts of these.
  localparam logic [DIV_W-1:0] NOTE_DIV [12] = '{
    19'd183469, 19'd173170, 19'd163452, 19'd154277, 19'd145619, 19'd137446,
    19'd129731, 19'd122450, 19'd115577, 19'd109091, 19'd102968, 19'd97189
  };

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h7F;
  localparam logic [7:0] Q_MID     = 8'd127;

  typedef enum logic [0:0] {
    SILENT = 1'b0,
    RUN    = 1'b1
  } osc_state_e;

  function automatic logic [DIV_W-1:0] base_div(input logic [NOTE_W-1:0] note);
    logic [DIV_W-1:0] d;
    case (note)
      4'd1:    d = NOTE_DIV[0];
      4'd2:    d = NOTE_DIV[1];
      4'd3:    d = NOTE_DIV[2];
      4'd4:    d = NOTE_DIV[3];
      4'd5:    d = NOTE_DIV[4];
      4'd6:    d = NOTE_DIV[5];
      4'd7:    d = NOTE_DIV[6];
      4'd8:    d = NOTE_DIV[7];
      4'd9:    d = NOTE_DIV[8];
      4'd10:   d = NOTE_DIV[9];
      4'd11:   d = NOTE_DIV[10];
      4'd12:   d = NOTE_DIV[11];
      default: d = DIV_ZERO;
    endcase
    return d;
  endfunction

  // Zero means silence; octave selects above 5 saturate at 5.
  function automatic logic [DIV_W-1:0] target_div(input logic [NOTE_W-1:0] note,
                                                  input logic [OCT_W-1:0]  oct);
    logic [OCT_W-1:0] sh;
    if (oct > OCT_MAX) begin
      sh = OCT_MAX;
    end else begin
      sh = oct;
    end
    return base_div(note) >> sh;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/note_oscillator_noise_lfsr.sv
// Galois right-shift LFSR (taps 8'hB8, seed 8'h7F) stepped once per period wrap.
// Exists only when OSC_NOISE_EN is defined.
`ifdef OSC_NOISE_EN
module noise_lfsr
  import osc_pkg::*;
(
  input  logic       clk,
  input  logic       Rst_i,
  input  logic       step_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_r;

  // Shift register advances only on a requested step
  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      lfsr_r <= LFSR_SEED;
    end else if (step_i) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign q_o = lfsr_r;

endmodule
`endif

// File: rtl/note_oscillator.sv
// Note/octave to period divisor converter with glitch-free free-running period counter.
// Define OSC_NOISE_EN to drive Q from noise_lfsr; otherwise Q is fixed mid-scale.
module note_oscillator
  import osc_pkg::*;
(
  input  logic              clk,
  input  logic              Rst_i,
  input  logic              en_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [OCT_W-1:0]  octave_i,
  output logic [DIV_W-1:0]  count,
  output logic [DIV_W-1:0]  divisor,
  output logic [7:0]        Q,
  output logic              wrap_o
);

  osc_state_e       state_r;
  osc_state_e       state_nxt_s;
  logic [DIV_W-1:0] count_r;
  logic [DIV_W-1:0] count_nxt_s;
  logic [DIV_W-1:0] divisor_r;
  logic [DIV_W-1:0] divisor_nxt_s;
  logic [DIV_W-1:0] pending_r;
  logic [DIV_W-1:0] target_s;
  logic             wrap_r;
  logic             wrap_nxt_s;

  assign target_s = target_div(note_i, octave_i);

  // Next-state, period counter and wrap decision
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = count_r;
    divisor_nxt_s = divisor_r;
    wrap_nxt_s    = 1'b0;
    if (en_i) begin
      case (state_r)
        SILENT: begin
          count_nxt_s = DIV_ZERO;
          if (target_s != DIV_ZERO) begin
            divisor_nxt_s = target_s;
            state_nxt_s   = RUN;
          end else begin
            divisor_nxt_s = DIV_ZERO;
            state_nxt_s   = SILENT;
          end
        end
        RUN: begin
          if (divisor_r == DIV_ZERO) begin
            count_nxt_s   = DIV_ZERO;
            divisor_nxt_s = DIV_ZERO;
            state_nxt_s   = SILENT;
          end else if (count_r >= divisor_r - DIV_ONE) begin
            // New note takes effect only here, so periods are never truncated
            count_nxt_s   = DIV_ZERO;
            wrap_nxt_s    = 1'b1;
            divisor_nxt_s = pending_r;
            if (pending_r == DIV_ZERO) begin
              state_nxt_s = SILENT;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            count_nxt_s = count_r + DIV_ONE;
          end
        end
        default: begin
          count_nxt_s   = DIV_ZERO;
          divisor_nxt_s = DIV_ZERO;
          state_nxt_s   = SILENT;
        end
      endcase
    end else begin
      wrap_nxt_s = 1'b0;
    end
  end

  // State, counter, divisor and wrap registers
  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      state_r   <= SILENT;
      count_r   <= DIV_ZERO;
      divisor_r <= DIV_ZERO;
      wrap_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      divisor_r <= divisor_nxt_s;
      wrap_r    <= wrap_nxt_s;
    end
  end

  // Pending divisor tracks the selected note on every enabled clock
  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      pending_r <= DIV_ZERO;
    end else if (en_i) begin
      pending_r <= target_s;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign count   = count_r;
  assign divisor = divisor_r;
  assign wrap_o  = wrap_r;

`ifdef OSC_NOISE_EN
  noise_lfsr u_noise_lfsr (
    .clk    (clk),
    .Rst_i  (Rst_i),
    .step_i (wrap_nxt_s),
    .q_o    (Q)
  );
`else
  assign Q = Q_MID;
`endif

endmodule

// File: tb/tb_note_oscillator.sv
// Scoreboard bench for note_oscillator: stimulus queues expected wrap events,
// a monitor pops and checks them whenever wrap_o pulses.
module tb_note_oscillator;

  logic        clk;
  logic        Rst_i;
  logic        en_i;
  logic [3:0]  note_i;
  logic [2:0]  octave_i;
  logic [18:0] count;
  logic [18:0] divisor;
  logic [7:0]  Q;
  logic        wrap_o;

  typedef struct {
    int unsigned period;
    logic [18:0] div;
    logic [7:0]  q;
  } wrap_exp_t;

  wrap_exp_t sb_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  note_oscillator dut (
    .clk      (clk),
    .Rst_i    (Rst_i),
    .en_i     (en_i),
    .note_i   (note_i),
    .octave_i (octave_i),
    .count    (count),
    .divisor  (divisor),
    .Q        (Q),
    .wrap_o   (wrap_o)
  );

  initial begin
    clk = 1'b0;
    #100;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] exp_q(input logic [7:0] noise_val);
`ifdef OSC_NOISE_EN
    return noise_val;
`else
    return 8'd127;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_wrap(input int unsigned period, input logic [18:0] div, input logic [7:0] q);
    wrap_exp_t e;
    e.period = period;
    e.div    = div;
    e.q      = exp_q(q);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic wait_count(input logic [18:0] target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (count == target) break;
      @(negedge clk);
    end
    check("reach_count", count, target);
  endtask

  // Monitor: counts enabled edges, checks each wrap against the scoreboard
  initial begin
    int unsigned edges;
    logic [18:0] prev_div;
    wrap_exp_t   e;
    edges    = 0;
    prev_div = '0;
    forever begin
      @(posedge clk or negedge clk);
      if (clk) begin
        if (Rst_i && en_i) edges++;
      end else begin
        if (wrap_o) begin
          if (sb_q.size() == 0) begin
            check("unexpected_wrap", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("wrap_period", edges, e.period);
            check("wrap_divisor", divisor, e.div);
            check("wrap_count", count, 0);
            check("wrap_q", Q, e.q);
          end
          edges = 0;
        end else if (divisor != 19'd0 && prev_div == 19'd0) begin
          edges = 0;
        end
        prev_div = divisor;
      end
    end
  end

  initial begin
    Rst_i    = 1'b0;
    en_i     = 1'b0;
    note_i   = 4'd0;
    octave_i = 3'd0;

    // Reset held with no clock edges
    #10;
    check("rst_count", count, 0);
    check("rst_divisor", divisor, 0);
    check("rst_q", Q, 8'h7F);
    check("rst_wrap", wrap_o, 0);
    #40;
    Rst_i = 1'b1;
    en_i  = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_divisor", divisor, 0);
    check("idle_count", count, 0);
    check("idle_q", Q, 8'h7F);

    // A, octave 0: one-clock load latency
    note_i = 4'd10;
    @(negedge clk);
    check("load_a0_divisor", divisor, 109091);
    check("load_a0_count", count, 0);
    repeat (10) @(negedge clk);
    check("a0_count_10", count, 10);

    // Asynchronous reset mid-run
    Rst_i = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_divisor", divisor, 0);
    check("async_rst_q", Q, 8'h7F);
    repeat (2) @(negedge clk);

    // A, octave 3 from silence
    Rst_i    = 1'b1;
    note_i   = 4'd10;
    octave_i = 3'd3;
    push_wrap(13636, 19'd13636, 8'h87);
    @(negedge clk);
    check("load_a3_divisor", divisor, 13636);
    check("load_a3_count", count, 0);
    wait_drain(20000);

    // Mid-period change to C takes effect at the next wrap
    wait_count(19'd5000, 10000);
    note_i = 4'd1;
    push_wrap(13636, 19'd22933, 8'hFB);
    repeat (100) @(negedge clk);
    check("div_hold_mid", divisor, 13636);
    wait_drain(20000);

    // Enable freeze inside the C period, then switch to silence
    push_wrap(22933, 19'd0, 8'hC5);
    wait_count(19'd100, 1000);
    en_i = 1'b0;
    repeat (20) @(negedge clk);
    check("freeze_count", count, 100);
    check("freeze_divisor", divisor, 22933);
    en_i = 1'b1;
    @(negedge clk);
    check("resume_count", count, 101);
    wait_count(19'd200, 1000);
    note_i = 4'd0;
    wait_drain(30000);
    repeat (50) @(negedge clk);
    check("silent_divisor", divisor, 0);
    check("silent_count", count, 0);

    // B with octave 7 clamps to a shift of 5; note 13 counts as silence
    note_i   = 4'd12;
    octave_i = 3'd7;
    push_wrap(3037, 19'd0, 8'hDA);
    @(negedge clk);
    check("load_b7_divisor", divisor, 3037);
    repeat (10) @(negedge clk);
    note_i = 4'd13;
    wait_drain(5000);
    repeat (10) @(negedge clk);
    check("note13_divisor", divisor, 0);
    check("note13_count", count, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
